// File: rtl/chan_mux_rr.sv
// N:1 channel multiplexer with a registered output stage and valid/ready on every port.
// A channel is granted either by the sel port (MODE=0) or round-robin over valid channels (MODE=1).
module chan_mux_rr #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(CH_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [CH_NUM*DATA_W-1:0] i_in_data,
    input  logic [CH_NUM-1:0]        i_in_valid,
    output logic [CH_NUM-1:0]        o_in_ready,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [SEL_W-1:0]         o_out_ch
);

    localparam logic [SEL_W:0]   CH_NUM_W = (SEL_W + 1)'(CH_NUM);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CH_NUM - 1);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [SEL_W-1:0]  r_ch;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_ok;
    logic [SEL_W:0]    w_scan;
    logic [CH_NUM-1:0] w_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_xfer;

    assign w_load = ~r_valid | i_out_ready;

    always_comb begin
        w_grant    = '0;
        w_grant_ok = 1'b0;
        w_scan     = '0;
        if (MODE == 0) begin
            w_grant    = i_sel;
            w_grant_ok = ({1'b0, i_sel} < CH_NUM_W);
        end else begin
            // Scan from the far end back toward ptr so the nearest valid channel wins last.
            for (int k = CH_NUM - 1; k >= 0; k--) begin
                w_scan = {1'b0, r_ptr} + (SEL_W + 1)'(k);
                if (w_scan >= CH_NUM_W) begin
                    w_scan = w_scan - CH_NUM_W;
                end
                if (i_in_valid[w_scan[SEL_W-1:0]]) begin
                    w_grant    = w_scan[SEL_W-1:0];
                    w_grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_ready[i] = w_load & w_grant_ok;
                w_data     = i_in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer     = |(i_in_valid & w_ready);
    assign o_in_ready = w_ready;

    // A full register that is not being drained holds everything, including ptr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_data;
                r_ch   <= w_grant;
                if (MODE == 1) begin
                    r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
                end
            end
        end
    end

    assign o_out_data  = r_data;
    assign o_out_valid = r_valid;
    assign o_out_ch    = r_ch;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: explicit-select and round-robin instances at 4 and 3 channels.
// Drivers push hand-computed {ch,data} beats; per-instance monitors pop them on output handshakes.
module tb_chan_mux_rr;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] inDataA, inDataB;
    logic [3:0]  inValidA, inReadyA, inValidB, inReadyB;
    logic [1:0]  selA, selB, outChA, outChB;
    logic [7:0]  outDataA, outDataB;
    logic        outValidA, outReadyA, outValidB, outReadyB;

    logic [23:0] inDataC, inDataD;
    logic [2:0]  inValidC, inReadyC, inValidD, inReadyD;
    logic [1:0]  selC, selD, outChC, outChD;
    logic [7:0]  outDataC, outDataD;
    logic        outValidC, outReadyC, outValidD, outReadyD;

    chan_mux_rr #(.CH_NUM(4), .DATA_W(8), .MODE(0)) uA (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inDataA), .i_in_valid(inValidA),
        .o_in_ready(inReadyA), .i_sel(selA), .o_out_data(outDataA),
        .o_out_valid(outValidA), .i_out_ready(outReadyA), .o_out_ch(outChA));

    chan_mux_rr #(.CH_NUM(4), .DATA_W(8), .MODE(1)) uB (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inDataB), .i_in_valid(inValidB),
        .o_in_ready(inReadyB), .i_sel(selB), .o_out_data(outDataB),
        .o_out_valid(outValidB), .i_out_ready(outReadyB), .o_out_ch(outChB));

    chan_mux_rr #(.CH_NUM(3), .DATA_W(8), .MODE(1)) uC (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inDataC), .i_in_valid(inValidC),
        .o_in_ready(inReadyC), .i_sel(selC), .o_out_data(outDataC),
        .o_out_valid(outValidC), .i_out_ready(outReadyC), .o_out_ch(outChC));

    chan_mux_rr #(.CH_NUM(3), .DATA_W(8), .MODE(0)) uD (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inDataD), .i_in_valid(inValidD),
        .o_in_ready(inReadyD), .i_sel(selD), .o_out_data(outDataD),
        .o_out_valid(outValidD), .i_out_ready(outReadyD), .o_out_ch(outChD));

    int checks   = 0;
    int failures = 0;
    logic [9:0] expQ [4][$];

    logic [1:0] chSeqB [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                2'd1, 2'd3, 2'd1, 2'd3};
    logic [1:0] chSeqC [6]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic pushExp(input int k, input logic [1:0] ch, input logic [7:0] data);
        expQ[k].push_back({ch, data});
    endtask

    task automatic monitorStep(input int k, input logic v, input logic r, input logic [9:0] beat);
        logic [9:0] want;
        if (rstN && v && r) begin
            if (expQ[k].size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected beat dut%0d: got %0h expected none", k, beat);
            end else begin
                want = expQ[k].pop_front();
                checkOutput($sformatf("beat dut%0d", k), 32'(beat), 32'(want));
            end
        end
    endtask

    always @(negedge clk) monitorStep(0, outValidA, outReadyA, {outChA, outDataA});
    always @(negedge clk) monitorStep(1, outValidB, outReadyB, {outChB, outDataB});
    always @(negedge clk) monitorStep(2, outValidC, outReadyC, {outChC, outDataC});
    always @(negedge clk) monitorStep(3, outValidD, outReadyD, {outChD, outDataD});

    task automatic applyStimulus(input int k, input logic [3:0] valid, input logic [1:0] s,
                                 input logic ready);
        case (k)
            0: begin inValidA = valid;      selA = s; outReadyA = ready; end
            1: begin inValidB = valid;      selB = s; outReadyB = ready; end
            2: begin inValidC = valid[2:0]; selC = s; outReadyC = ready; end
            default: begin inValidD = valid[2:0]; selD = s; outReadyD = ready; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        inDataA = {8'h44, 8'hA5, 8'h22, 8'h11};
        inDataB = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        inDataC = {8'hC2, 8'hC1, 8'hC0};
        inDataD = {8'hD2, 8'hD1, 8'hD0};
        for (int k = 0; k < 4; k++) applyStimulus(k, 4'b0000, 2'd0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(outValidA), 0);
        checkOutput("reset out_data", 32'(outDataA), 0);
        checkOutput("reset out_ch", 32'(outChA), 0);
        checkOutput("reset out_valid rr", 32'(outValidB), 0);
        rstN = 1'b1;

        // Explicit select of channel 2
        applyStimulus(0, 4'b0100, 2'd2, 1'b1);
        pushExp(0, 2'd2, 8'hA5);
        @(negedge clk);
        checkOutput("t2 in_ready", 32'(inReadyA), 32'h4);
        step();
        applyStimulus(0, 4'b0000, 2'd2, 1'b1);
        checkOutput("t2 out_valid", 32'(outValidA), 1);
        checkOutput("t2 out_data", 32'(outDataA), 32'hA5);
        checkOutput("t2 out_ch", 32'(outChA), 2);
        @(negedge clk);
        checkOutput("t2 ready without valid", 32'(inReadyA), 32'h4);
        step();
        checkOutput("t2 bubble", 32'(outValidA), 0);
        checkOutput("t2 data hold", 32'(outDataA), 32'hA5);

        // Backpressure: held beat must survive toggling inputs
        inDataA[23:16] = 8'h3C;
        applyStimulus(0, 4'b0100, 2'd2, 1'b0);
        pushExp(0, 2'd2, 8'h3C);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'b1111, 2'(i), 1'b0);
            inDataA = inDataA ^ 32'hFFFF_FFFF;
            @(negedge clk);
            checkOutput("t3 in_ready stalled", 32'(inReadyA), 0);
            checkOutput("t3 data stable", 32'(outDataA), 32'h3C);
            checkOutput("t3 valid stable", 32'(outValidA), 1);
            step();
        end
        inDataA[15:8] = 8'h5A;
        applyStimulus(0, 4'b0010, 2'd1, 1'b1);
        pushExp(0, 2'd1, 8'h5A);
        @(negedge clk);
        checkOutput("t3 ready on drain", 32'(inReadyA), 32'h2);
        step();
        applyStimulus(0, 4'b0000, 2'd1, 1'b1);
        checkOutput("t3 fill valid", 32'(outValidA), 1);
        checkOutput("t3 fill data", 32'(outDataA), 32'h5A);
        checkOutput("t3 fill ch", 32'(outChA), 1);
        step();
        checkOutput("t3 drained", 32'(outValidA), 0);

        // Asynchronous reset while a beat is held
        inDataA[7:0] = 8'h77;
        applyStimulus(0, 4'b0001, 2'd0, 1'b0);
        step();
        applyStimulus(0, 4'b0000, 2'd0, 1'b0);
        checkOutput("t1 held valid", 32'(outValidA), 1);
        checkOutput("t1 held data", 32'(outDataA), 32'h77);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t1 async out_valid", 32'(outValidA), 0);
        checkOutput("t1 async out_data", 32'(outDataA), 0);
        checkOutput("t1 async out_ch", 32'(outChA), 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 4'b0000, 2'd0, 1'b1);
        step();

        // Round-robin, all valid then sparse 4'b1010
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        for (int n = 0; n < 12; n++) begin
            pushExp(1, chSeqB[n], 8'hB0 + 8'(chSeqB[n]));
            @(negedge clk);
            checkOutput($sformatf("t4 in_ready beat%0d", n), 32'(inReadyB),
                        32'(4'b0001 << chSeqB[n]));
            if (n > 0) checkOutput("t4 no bubble", 32'(outValidB), 1);
            step();
            if (n == 7) applyStimulus(1, 4'b1010, 2'd0, 1'b1);
        end
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        pushExp(1, 2'd0, 8'hB0);
        @(negedge clk);
        checkOutput("t5 ptr wrap 3->0", 32'(inReadyB), 32'h1);
        step();
        applyStimulus(1, 4'b0000, 2'd0, 1'b1);

        // Three channels, round-robin wrap 2->0
        applyStimulus(2, 4'b0111, 2'd0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            pushExp(2, chSeqC[n], 8'hC0 + 8'(chSeqC[n]));
            @(negedge clk);
            checkOutput($sformatf("t6 rr3 in_ready beat%0d", n), 32'(inReadyC),
                        32'(3'b001 << chSeqC[n]));
            step();
        end
        applyStimulus(2, 4'b0000, 2'd0, 1'b1);

        // Three channels, select 3 is out of range
        applyStimulus(3, 4'b0111, 2'd1, 1'b1);
        pushExp(3, 2'd1, 8'hD1);
        @(negedge clk);
        checkOutput("t6 sel1 in_ready", 32'(inReadyD), 32'h2);
        step();
        applyStimulus(3, 4'b0111, 2'd3, 1'b1);
        @(negedge clk);
        checkOutput("t6 invalid sel in_ready", 32'(inReadyD), 0);
        checkOutput("t6 draining valid", 32'(outValidD), 1);
        step();
        checkOutput("t6 invalid sel valid drop", 32'(outValidD), 0);
        checkOutput("t6 out_ch hold", 32'(outChD), 1);

        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("queue empty dut%0d", k), 32'(expQ[k].size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
